// File: rtl/axi_wr_mux.sv
// Merges INPUT_NUM AXI write masters onto one port: round-robin AW, AW-ordered W, BID-decoded B; all paths zero-latency.
// AW stalls while the W-order FIFO is full or downstream AWREADY is low; W stalls until its AW is queued; B follows the routed BREADY.
module axi_wr_mux #(
    parameter int          INPUT_NUM                   = 3,
    parameter int unsigned ID_ROUTING [INPUT_NUM+1]    = '{0, 1, 2, 3},
    parameter int          FIFO_DEPTH                  = 4
) (
    input  logic                          ACLK,
    input  logic                          ARESETn,

    input  logic [INPUT_NUM-1:0][3:0]     s_awid,
    input  logic [INPUT_NUM-1:0][31:0]    s_awaddr,
    input  logic [INPUT_NUM-1:0][7:0]     s_awlen,
    input  logic [INPUT_NUM-1:0][2:0]     s_awsize,
    input  logic [INPUT_NUM-1:0][1:0]     s_awburst,
    input  logic [INPUT_NUM-1:0]          s_awvalid,
    output logic [INPUT_NUM-1:0]          s_awready,
    input  logic [INPUT_NUM-1:0][31:0]    s_wdata,
    input  logic [INPUT_NUM-1:0][3:0]     s_wstrb,
    input  logic [INPUT_NUM-1:0]          s_wlast,
    input  logic [INPUT_NUM-1:0]          s_wvalid,
    output logic [INPUT_NUM-1:0]          s_wready,
    output logic [INPUT_NUM-1:0][3:0]     s_bid,
    output logic [INPUT_NUM-1:0][1:0]     s_bresp,
    output logic [INPUT_NUM-1:0]          s_bvalid,
    input  logic [INPUT_NUM-1:0]          s_bready,

    output logic [3:0]                    m_awid,
    output logic [31:0]                   m_awaddr,
    output logic [7:0]                    m_awlen,
    output logic [2:0]                    m_awsize,
    output logic [1:0]                    m_awburst,
    output logic                          m_awvalid,
    input  logic                          m_awready,
    output logic [31:0]                   m_wdata,
    output logic [3:0]                    m_wstrb,
    output logic                          m_wlast,
    output logic                          m_wvalid,
    input  logic                          m_wready,
    input  logic [3:0]                    m_bid,
    input  logic [1:0]                    m_bresp,
    input  logic                          m_bvalid,
    output logic                          m_bready
);
    localparam int IW = (INPUT_NUM > 1) ? $clog2(INPUT_NUM) : 1;
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic {ARB_OPEN, ARB_LOCKED} arb_state_t;

    arb_state_t    state, state_nxt;
    logic [IW-1:0] rr_ptr, lock_idx, grant, search_idx;
    logic          search_hit, aw_req, aw_hs, w_hs;
    int            cand;

    logic [IW-1:0] order_mem [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count;
    logic          fifo_full, fifo_empty, push, pop;
    logic [IW-1:0] head;

    logic          b_hit;
    logic [IW-1:0] b_sel;

    // ---------------- AW arbitration ----------------
    always_comb begin
        search_idx = '0;
        search_hit = 1'b0;
        cand       = 0;
        for (int k = 0; k < INPUT_NUM; k++) begin
            cand = int'(rr_ptr) + k;
            if (cand >= INPUT_NUM)
                cand = cand - INPUT_NUM;
            if (!search_hit && s_awvalid[cand]) begin
                search_hit = 1'b1;
                search_idx = IW'(cand);
            end
        end
    end

    always_comb begin
        state_nxt = state;
        grant     = (state == ARB_LOCKED) ? lock_idx : search_idx;
        aw_req    = (state == ARB_LOCKED) ? s_awvalid[lock_idx] : search_hit;
        m_awvalid = ARESETn && !fifo_full && aw_req;
        aw_hs     = m_awvalid && m_awready;
        s_awready = '0;
        if (m_awvalid)
            s_awready[grant] = m_awready;
        // Once offered downstream the grant must not move until accepted
        if (aw_hs)
            state_nxt = ARB_OPEN;
        else if (m_awvalid)
            state_nxt = ARB_LOCKED;
    end

    always_comb begin
        m_awid    = s_awid[grant];
        m_awaddr  = s_awaddr[grant];
        m_awlen   = s_awlen[grant];
        m_awsize  = s_awsize[grant];
        m_awburst = s_awburst[grant];
    end

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            state    <= ARB_OPEN;
            lock_idx <= '0;
            rr_ptr   <= '0;
        end else begin
            state <= state_nxt;
            if (state == ARB_OPEN)
                lock_idx <= grant;
            if (aw_hs)
                rr_ptr <= (grant == IW'(INPUT_NUM - 1)) ? '0 : grant + IW'(1);
        end
    end

    // ---------------- W-order FIFO ----------------
    assign fifo_full  = (count == CW'(FIFO_DEPTH));
    assign fifo_empty = (count == '0);
    assign head       = order_mem[rd_ptr];
    assign push       = aw_hs;
    assign pop        = w_hs && m_wlast;

    always_ff @(posedge ACLK) begin
        if (push)
            order_mem[wr_ptr] <= grant;
    end

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + PW'(1);
            if (pop)
                rd_ptr <= rd_ptr + PW'(1);
            unique case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // ---------------- W routing ----------------
    always_comb begin
        m_wdata  = s_wdata[head];
        m_wstrb  = s_wstrb[head];
        m_wlast  = s_wlast[head];
        m_wvalid = ARESETn && !fifo_empty && s_wvalid[head];
        w_hs     = m_wvalid && m_wready;
        s_wready = '0;
        if (ARESETn && !fifo_empty)
            s_wready[head] = m_wready;
    end

    // ---------------- B routing ----------------
    always_comb begin
        b_hit = 1'b0;
        b_sel = '0;
        for (int i = 0; i < INPUT_NUM; i++) begin
            if (!b_hit && (32'(m_bid) >= ID_ROUTING[i]) && (32'(m_bid) < ID_ROUTING[i+1])) begin
                b_hit = 1'b1;
                b_sel = IW'(i);
            end
        end
    end

    always_comb begin
        s_bvalid = '0;
        for (int i = 0; i < INPUT_NUM; i++) begin
            s_bid[i]   = m_bid;
            s_bresp[i] = m_bresp;
        end
        if (ARESETn && b_hit)
            s_bvalid[b_sel] = m_bvalid;
        // Unrouted IDs are sunk so a stray response cannot wedge the channel
        m_bready = ARESETn && (b_hit ? s_bready[b_sel] : 1'b1);
    end

endmodule

// File: tb/tb_axi_wr_mux.sv
// Directed bench for axi_wr_mux: arbitration order, lock, FIFO full/empty, W ordering, B decode, async reset flush.
module tb_axi_wr_mux;
    localparam int N = 3;

    logic              clk, arst_n;
    logic [N-1:0][3:0]  s_awid;
    logic [N-1:0][31:0] s_awaddr;
    logic [N-1:0][7:0]  s_awlen;
    logic [N-1:0][2:0]  s_awsize;
    logic [N-1:0][1:0]  s_awburst;
    logic [N-1:0]       s_awvalid, s_awready;
    logic [N-1:0][31:0] s_wdata;
    logic [N-1:0][3:0]  s_wstrb;
    logic [N-1:0]       s_wlast, s_wvalid, s_wready;
    logic [N-1:0][3:0]  s_bid;
    logic [N-1:0][1:0]  s_bresp;
    logic [N-1:0]       s_bvalid, s_bready;
    logic [3:0]         m_awid;
    logic [31:0]        m_awaddr;
    logic [7:0]         m_awlen;
    logic [2:0]         m_awsize;
    logic [1:0]         m_awburst;
    logic               m_awvalid, m_awready;
    logic [31:0]        m_wdata;
    logic [3:0]         m_wstrb;
    logic               m_wlast, m_wvalid, m_wready;
    logic [3:0]         m_bid;
    logic [1:0]         m_bresp;
    logic               m_bvalid, m_bready;

    int checks = 0;
    int errors = 0;

    axi_wr_mux dut (
        .ACLK(clk), .ARESETn(arst_n),
        .s_awid(s_awid), .s_awaddr(s_awaddr), .s_awlen(s_awlen), .s_awsize(s_awsize),
        .s_awburst(s_awburst), .s_awvalid(s_awvalid), .s_awready(s_awready),
        .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wlast(s_wlast), .s_wvalid(s_wvalid),
        .s_wready(s_wready), .s_bid(s_bid), .s_bresp(s_bresp), .s_bvalid(s_bvalid),
        .s_bready(s_bready),
        .m_awid(m_awid), .m_awaddr(m_awaddr), .m_awlen(m_awlen), .m_awsize(m_awsize),
        .m_awburst(m_awburst), .m_awvalid(m_awvalid), .m_awready(m_awready),
        .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wlast(m_wlast), .m_wvalid(m_wvalid),
        .m_wready(m_wready), .m_bid(m_bid), .m_bresp(m_bresp), .m_bvalid(m_bvalid),
        .m_bready(m_bready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        arst_n    = 1'b0;
        m_awready = 1'b1;
        m_wready  = 1'b0;
        m_bvalid  = 1'b1;
        m_bid     = 4'd0;
        m_bresp   = 2'd0;
        s_awvalid = 3'b111;
        s_wvalid  = '0;
        s_wlast   = '0;
        s_bready  = 3'b001;
        for (int i = 0; i < N; i++) begin
            s_awid[i]    = 4'(i);
            s_awaddr[i]  = 32'h1000 * (i + 1);
            s_awlen[i]   = 8'd0;
            s_awsize[i]  = 3'd2;
            s_awburst[i] = 2'd1;
            s_wdata[i]   = 32'hA0 + i;
            s_wstrb[i]   = 4'hF;
        end
        #2;
        chk("rst_m_awvalid", 32'(m_awvalid), 0);
        chk("rst_s_awready", 32'(s_awready), 0);
        chk("rst_m_wvalid",  32'(m_wvalid),  0);
        chk("rst_m_bready",  32'(m_bready),  0);
        chk("rst_s_bvalid",  32'(s_bvalid),  0);

        // All three request together: accepted 0,1,2 on consecutive edges
        repeat (2) @(posedge clk);
        #1;
        arst_n   = 1'b1;
        m_bvalid = 1'b0;
        s_bready = '0;
        #1;
        chk("rr0_m_awvalid", 32'(m_awvalid), 1);
        chk("rr0_m_awid",    32'(m_awid),    0);
        chk("rr0_m_awaddr",  m_awaddr,       32'h1000);
        chk("rr0_s_awready", 32'(s_awready), 3'b001);
        step();
        s_awvalid = 3'b110;
        #1;
        chk("rr1_m_awid",    32'(m_awid),    1);
        chk("rr1_s_awready", 32'(s_awready), 3'b010);
        chk("rr1_s_wready",  32'(s_wready),  0);
        step();
        s_awvalid = 3'b100;
        #1;
        chk("rr2_m_awid",    32'(m_awid),    2);
        chk("rr2_s_awready", 32'(s_awready), 3'b100);
        step();
        s_awvalid = 3'b000;
        #1;
        chk("rr_done_m_awvalid", 32'(m_awvalid), 0);
        // Drain: the bursts come out in AW order 0,1,2
        m_wready = 1'b1;
        s_wvalid = 3'b111;
        s_wlast  = 3'b111;
        #1;
        chk("ord0_m_wdata",  m_wdata,       32'hA0);
        chk("ord0_s_wready", 32'(s_wready), 3'b001);
        step();
        chk("ord1_m_wdata",  m_wdata,       32'hA1);
        chk("ord1_s_wready", 32'(s_wready), 3'b010);
        step();
        chk("ord2_m_wdata",  m_wdata,       32'hA2);
        chk("ord2_s_wready", 32'(s_wready), 3'b100);
        step();
        chk("ord_empty_m_wvalid", 32'(m_wvalid), 0);
        chk("ord_empty_s_wready", 32'(s_wready), 0);

        // Grant lock: input 2 offered while stalled, input 0 must wait
        s_wvalid  = '0;
        m_wready  = 1'b0;
        m_awready = 1'b0;
        s_awvalid = 3'b100;
        #1;
        chk("lock_m_awid",    32'(m_awid),    2);
        chk("lock_s_awready", 32'(s_awready), 0);
        step();
        s_awvalid = 3'b101;
        #1;
        chk("lock_hold_m_awid", 32'(m_awid), 2);
        step();
        chk("lock_hold2_m_awid", 32'(m_awid), 2);
        m_awready = 1'b1;
        #1;
        chk("lock_rel_s_awready", 32'(s_awready), 3'b100);
        step();
        s_awvalid = 3'b001;
        #1;
        chk("lock_next_m_awid",    32'(m_awid),    0);
        chk("lock_next_s_awready", 32'(s_awready), 3'b001);
        step();
        s_awvalid = '0;
        m_wready  = 1'b1;
        s_wvalid  = 3'b101;
        #1;
        chk("lock_ord0_s_wready", 32'(s_wready), 3'b100);
        step();
        chk("lock_ord1_s_wready", 32'(s_wready), 3'b001);
        step();
        chk("lock_empty_m_wvalid", 32'(m_wvalid), 0);

        // FIFO full: five AWs from input 0 with W stalled, only four taken
        s_wvalid  = '0;
        m_wready  = 1'b0;
        s_awvalid = 3'b001;
        #1;
        chk("full_first_m_awvalid", 32'(m_awvalid), 1);
        repeat (4) step();
        chk("full_m_awvalid",  32'(m_awvalid), 0);
        chk("full_s_awready",  32'(s_awready), 0);
        step();
        chk("full_hold_m_awvalid", 32'(m_awvalid), 0);
        s_wvalid = 3'b001;
        s_wlast  = 3'b001;
        m_wready = 1'b1;
        #1;
        chk("full_pop_m_wvalid",  32'(m_wvalid),  1);
        chk("full_pop_m_awvalid", 32'(m_awvalid), 0);
        step();
        s_wvalid = '0;
        m_wready = 1'b0;
        #1;
        chk("freed_m_awvalid", 32'(m_awvalid), 1);
        step();
        chk("refull_m_awvalid", 32'(m_awvalid), 0);
        s_awvalid = '0;
        s_wvalid  = 3'b001;
        m_wready  = 1'b1;
        repeat (4) step();
        chk("full_drain_m_wvalid", 32'(m_wvalid), 0);

        // W before AW: input 0 has no AW and must never be forwarded
        s_wdata[0] = 32'hDEAD;
        s_wlast    = 3'b000;
        s_awlen[1] = 8'd1;
        s_awvalid  = 3'b010;
        s_wvalid   = 3'b011;
        s_wdata[1] = 32'h11;
        #1;
        chk("early_m_awid",    32'(m_awid),    1);
        chk("early_m_awlen",   32'(m_awlen),   1);
        chk("early_m_wvalid",  32'(m_wvalid),  0);
        chk("early_s_wready",  32'(s_wready),  0);
        step();
        s_awvalid = '0;
        #1;
        chk("beat1_m_wvalid", 32'(m_wvalid), 1);
        chk("beat1_m_wdata",  m_wdata,       32'h11);
        chk("beat1_s_wready", 32'(s_wready), 3'b010);
        step();
        s_wdata[1] = 32'h12;
        s_wlast    = 3'b010;
        #1;
        chk("beat2_m_wdata", m_wdata,       32'h12);
        chk("beat2_m_wlast", 32'(m_wlast),  1);
        step();
        chk("after_m_wvalid", 32'(m_wvalid), 0);
        chk("after_s_wready", 32'(s_wready), 0);
        s_wvalid   = '0;
        s_awlen[1] = 8'd0;

        // B routing by ID range, and unrouted ID sink
        m_bvalid = 1'b1;
        m_bid    = 4'd2;
        m_bresp  = 2'b10;
        s_bready = '0;
        #1;
        chk("b2_s_bvalid", 32'(s_bvalid),   3'b100);
        chk("b2_m_bready", 32'(m_bready),   0);
        chk("b2_s_bid",    32'(s_bid[2]),   2);
        chk("b2_s_bresp",  32'(s_bresp[2]), 2);
        s_bready = 3'b100;
        #1;
        chk("b2_rdy_m_bready", 32'(m_bready), 1);
        m_bid    = 4'd7;
        s_bready = '0;
        #1;
        chk("b7_m_bready", 32'(m_bready), 1);
        chk("b7_s_bvalid", 32'(s_bvalid), 0);
        m_bid    = 4'd0;
        s_bready = 3'b001;
        #1;
        chk("b0_s_bvalid", 32'(s_bvalid), 3'b001);
        chk("b0_m_bready", 32'(m_bready), 1);

        // Reset between beats of a 2-beat burst
        s_awlen[0] = 8'd1;
        s_awvalid  = 3'b001;
        s_wlast    = '0;
        s_wdata[0] = 32'hB1;
        #1;
        chk("mid_m_awid", 32'(m_awid), 0);
        step();
        s_awvalid = '0;
        s_wvalid  = 3'b001;
        #1;
        chk("mid_b1_m_wvalid", 32'(m_wvalid), 1);
        step();
        s_wdata[0] = 32'hB2;
        s_wlast    = 3'b001;
        s_awvalid  = 3'b010;
        #1;
        arst_n = 1'b0;
        #1;
        chk("arst_m_wvalid",  32'(m_wvalid),  0);
        chk("arst_s_wready",  32'(s_wready),  0);
        chk("arst_m_awvalid", 32'(m_awvalid), 0);
        chk("arst_s_awready", 32'(s_awready), 0);
        chk("arst_m_bready",  32'(m_bready),  0);
        chk("arst_s_bvalid",  32'(s_bvalid),  0);
        arst_n    = 1'b1;
        s_awvalid = 3'b111;
        #1;
        chk("post_m_wvalid",  32'(m_wvalid),  0);
        chk("post_s_wready",  32'(s_wready),  0);
        chk("post_m_awid",    32'(m_awid),    0);
        chk("post_s_awready", 32'(s_awready), 3'b001);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/axi_wr_mux.md
AXI_WR_MUX -- requirements
Module: axi_wr_mux

Interface
REQ-001 Parameter INPUT_NUM, default 3: number of upstream AXI write masters merged onto one output.
REQ-002 Parameter ID_ROUTING, default '{0,1,2,3}: ID boundaries (INPUT_NUM+1 entries); input i owns BIDs in [ID_ROUTING[i], ID_ROUTING[i+1]).
REQ-003 Parameter FIFO_DEPTH, default 4: depth of the W-order FIFO (power of two, >=2).
REQ-004 ACLK  input  1  clock; all state updates on rising edge.
REQ-005 ARESETn  input  1  reset, asynchronous, active-low.
REQ-006 s_axi_in  axi_if slave side  [INPUT_NUM]  upstream masters: AW (AWID 4, AWADDR 32, AWLEN 8, AWSIZE 3, AWBURST 2), W (WDATA 32, WSTRB 4, WLAST), B (BID 4, BRESP 2), plus VALID/READY for each channel.
REQ-007 m_axi_out  axi_if master side  1  merged downstream port feeding the ID-routed demux; same signal set.

Function
REQ-008 AW arbitration SHALL be round-robin over s_axi_in[i].AWVALID; search starts at rr_ptr; rr_ptr resets to 0.
REQ-009 Once m_axi_out.AWVALID is high, the grant SHALL be locked until the AW handshake (AWVALID && AWREADY), even if another input with higher priority raises AWVALID.
REQ-010 AW payload SHALL pass combinationally from the granted input to m_axi_out (zero-cycle latency); only the granted input sees AWREADY = m_axi_out.AWREADY; all others see AWREADY=0.
REQ-011 On AW handshake: the granted index SHALL be pushed into the W-order FIFO; rr_ptr <= (grant+1) mod INPUT_NUM; the grant SHALL unlock.
REQ-012 When the W-order FIFO is full: m_axi_out.AWVALID=0 and all s AWREADY=0; push SHALL be blocked even if a pop occurs in the same cycle.
REQ-013 W routing SHALL be decided by the FIFO head: m_axi_out W payload/WVALID come from s_axi_in[head]; only s_axi_in[head].WREADY = m_axi_out.WREADY.
REQ-014 FIFO empty: m_axi_out.WVALID=0 and all s WREADY=0; there is no bypass, so W for a burst is forwarded no earlier than the cycle after its AW handshake.
REQ-015 The FIFO SHALL pop on a W handshake with WLAST=1; the next beat SHALL be taken from the new head in the following cycle.
REQ-016 W beats from an input whose AW has not yet been accepted SHALL stall (WREADY=0); the block SHALL NOT reorder bursts relative to AW acceptance order.
REQ-017 B routing SHALL decode m_axi_out.BID against ID_ROUTING to select input i: s_axi_in[i].BVALID/BID/BRESP = m side; m_axi_out.BREADY = s_axi_in[i].BREADY; all other s BVALID=0.
REQ-018 A BID outside all ranges SHALL assert m_axi_out.BREADY=1 and discard the response, with no s BVALID asserted.
REQ-019 B routing SHALL be independent of AW/W state; B, AW and W SHALL be able to handshake in the same cycle.
REQ-020 The FIFO occupancy counter SHALL be log2(FIFO_DEPTH)+1 bits wide; read/write pointers SHALL wrap modulo FIFO_DEPTH.

Reset
REQ-021 While ARESETn=0: FIFO empty, rr_ptr=0, grant unlocked, m_axi_out AWVALID/WVALID/BREADY=0, all s AWREADY/WREADY/BVALID=0.
REQ-022 Reset asserted mid-burst SHALL flush the FIFO immediately; outstanding W beats are dropped and the upstream masters must reissue.
REQ-023 After deassertion the first AW SHALL be accepted no earlier than the first rising ACLK edge with ARESETn=1.

Verification
REQ-024 Inputs 0,1,2 raise AWVALID together, with AWREADY held high -> AW accepted in order 0,1,2 on consecutive cycles; FIFO holds 0,1,2.
REQ-025 FIFO_DEPTH=4, WREADY held 0, inputs issue 5 AWs -> 4 are accepted, then AWVALID out=0 until the first WLAST handshake frees a slot.
REQ-026 Input 1 issues AW (AWLEN=1) with W beats 1,2 already valid, while input 0 W is valid without an AW -> only input 1 W is forwarded, starting the cycle after its AW handshake; input 0 WREADY stays 0.
REQ-027 BID=2 with BVALID while s[2].BREADY=0 -> s[2].BVALID=1 and others 0; m BREADY=0 until s[2].BREADY=1; BID=7 -> m BREADY=1 and no s BVALID.
REQ-028 ARESETn pulsed low between beat 1 and beat 2 of a 2-beat burst -> all outputs go to reset values asynchronously; the FIFO is empty and rr_ptr=0 after release.
REQ-029 Input 2 holds AWVALID while m AWREADY=0 and input 0 raises AWVALID -> the grant stays with input 2 until its handshake, then passes to input 0.
